// File: rtl/ram_net_pkg.sv
// Shared types and helpers for the RAM <-> network datapath blocks.
package ram_net_pkg;

   // Width of an index over n items; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int RN_LANES  = 32;
   localparam int RN_DATA_W = 32;
   localparam int RN_LANE_W = id_w(RN_LANES);

   // Default-width response word as exchanged with the network side.
   typedef struct packed {
      logic [RN_LANE_W-1:0] dst;
      logic [RN_DATA_W-1:0] data;
   } ram_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
   import ram_net_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          enable,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);

   logic [IW-1:0] k;

   // Scan from ptr upward; the first hit wins and blocks later candidates.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      k         = '0;
      for (int i = 0; i < N; i++) begin
         k = IW'((int'(ptr) + i) % N);
         if (enable && !any_grant && req[k]) begin
            any_grant = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = k;
         end
      end
   end

endmodule

// File: rtl/ram_network_return_router.sv
// Return path RAM banks -> network lanes: per-bank FIFOs, per-lane
// round-robin arbitration, registered valid/ready output per lane.
module ram_network_return_router
   import ram_net_pkg::*;
#(
   parameter int NUM_LANES     = 32,
   parameter int NUM_BANKS     = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int LANE_ID_WIDTH = id_w(NUM_LANES),
   parameter int BANK_ID_WIDTH = id_w(NUM_BANKS),
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]      bank_val,
   input  logic [NUM_BANKS-1:0][LANE_ID_WIDTH-1:0]   bank_dst,
   input  logic [NUM_BANKS-1:0]                      bank_valid,
   output logic [NUM_BANKS-1:0]                      bank_ready,
   output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      out_val,
   output logic [NUM_LANES-1:0][BANK_ID_WIDTH-1:0]   out_src,
   output logic [NUM_LANES-1:0]                      out_valid,
   input  logic [NUM_LANES-1:0]                      out_ready,
   output logic                                      drop_err
);

   localparam int PTR_W = id_w(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   // One extra bit so every tag value, including all-ones, compares correctly.
   localparam logic [LANE_ID_WIDTH:0] LANE_LIMIT = (LANE_ID_WIDTH+1)'(NUM_LANES);

   typedef struct packed {
      logic [LANE_ID_WIDTH-1:0] dst;
      logic [DATA_WIDTH-1:0]    data;
   } bank_resp_t;

   bank_resp_t [NUM_BANKS-1:0][FIFO_DEPTH-1:0] fifo_mem;
   bank_resp_t [NUM_BANKS-1:0]                 head;
   logic [NUM_BANKS-1:0][PTR_W-1:0]            wr_ptr, rd_ptr;
   logic [NUM_BANKS-1:0][CNT_W-1:0]            count;
   logic [NUM_BANKS-1:0]                       push, pop, drop, head_valid;

   logic [NUM_LANES-1:0][NUM_BANKS-1:0]        req, grant;
   logic [NUM_LANES-1:0][BANK_ID_WIDTH-1:0]    grant_idx, rr_ptr;
   logic [NUM_LANES-1:0]                       any_grant, load;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      // Ready uses the pre-pop count: a full FIFO never takes a word.
      assign bank_ready[b] = (count[b] != CNT_W'(FIFO_DEPTH));
      assign push[b]       = bank_valid[b] && bank_ready[b];
      assign head_valid[b] = (count[b] != '0);
      assign head[b]       = fifo_mem[b][rd_ptr[b]];
      assign drop[b]       = head_valid[b] && ({1'b0, head[b].dst} >= LANE_LIMIT);

      // Storage write; contents need no reset since count gates visibility.
      always_ff @(posedge clk) begin
         if (push[b]) fifo_mem[b][wr_ptr[b]] <= '{dst: bank_dst[b], data: bank_val[b]};
      end

      // Pointer and occupancy update; push and pop may coincide.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            wr_ptr[b] <= '0;
            rd_ptr[b] <= '0;
            count[b]  <= '0;
         end else begin
            if (push[b]) wr_ptr[b] <= wr_ptr[b] + PTR_W'(1);
            if (pop[b])  rd_ptr[b] <= rd_ptr[b] + PTR_W'(1);
            count[b] <= count[b] + CNT_W'(push[b]) - CNT_W'(pop[b]);
         end
      end
   end

   // A head leaves when some lane grants it or when its tag is out of range.
   always_comb begin
      pop = drop;
      for (int l = 0; l < NUM_LANES; l++) pop = pop | grant[l];
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      for (genvar b = 0; b < NUM_BANKS; b++) begin : g_req
         assign req[l][b] = head_valid[b] && (head[b].dst == LANE_ID_WIDTH'(l));
      end

      assign load[l] = !out_valid[l] || out_ready[l];

      rr_arbiter #(.N(NUM_BANKS), .IW(BANK_ID_WIDTH)) u_arb (
         .req       (req[l]),
         .ptr       (rr_ptr[l]),
         .enable    (load[l]),
         .grant     (grant[l]),
         .grant_idx (grant_idx[l]),
         .any_grant (any_grant[l])
      );

      // Output register: load a granted head, drain when idle, hold on stall.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            out_valid[l] <= 1'b0;
            out_val[l]   <= '0;
            out_src[l]   <= '0;
            rr_ptr[l]    <= '0;
         end else if (load[l]) begin
            if (any_grant[l]) begin
               out_valid[l] <= 1'b1;
               out_val[l]   <= head[grant_idx[l]].data;
               out_src[l]   <= grant_idx[l];
               rr_ptr[l]    <= (grant_idx[l] == BANK_ID_WIDTH'(NUM_BANKS-1)) ?
                               '0 : grant_idx[l] + BANK_ID_WIDTH'(1);
            end else begin
               out_valid[l] <= 1'b0;
            end
         end
      end
   end

   // Sticky error flag for discarded out-of-range responses.
   always_ff @(posedge clk) begin
      if (!rst_n)     drop_err <= 1'b0;
      else if (|drop) drop_err <= 1'b1;
   end

endmodule

// File: tb/tb_ram_network_return_router.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based reference model.
module tb_ram_network_return_router;

   localparam int NL = 24;
   localparam int NB = 4;
   localparam int DW = 32;
   localparam int LW = 5;
   localparam int BW = 2;
   localparam int FD = 16;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NB-1:0][DW-1:0]  bank_val;
   logic [NB-1:0][LW-1:0]  bank_dst;
   logic [NB-1:0]          bank_valid, bank_ready;
   logic [NL-1:0][DW-1:0]  out_val;
   logic [NL-1:0][BW-1:0]  out_src;
   logic [NL-1:0]          out_valid, out_ready;
   logic                   drop_err;

   always #5 clk = ~clk;

   ram_network_return_router #(
      .NUM_LANES(NL), .NUM_BANKS(NB), .DATA_WIDTH(DW),
      .LANE_ID_WIDTH(LW), .BANK_ID_WIDTH(BW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bank_val(bank_val), .bank_dst(bank_dst),
      .bank_valid(bank_valid), .bank_ready(bank_ready), .out_val(out_val),
      .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
      .drop_err(drop_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: one queue per bank, one output slot per lane.
   typedef struct { int dst; logic [31:0] data; } mw_t;
   mw_t         mq[NB][$];
   logic [NL-1:0] m_ov;
   logic [31:0] m_val[NL];
   int          m_src[NL];
   int          m_ptr[NL];
   logic        m_derr;

   task automatic model_step();
      bit hv[NB]; int hd[NB]; bit pp[NB]; bit rdy[NB];
      int g, b;
      mw_t w;
      if (!rst_n) begin
         for (int i = 0; i < NB; i++) mq[i].delete();
         m_ov = '0; m_derr = 1'b0;
         for (int l = 0; l < NL; l++) begin m_val[l] = 0; m_src[l] = 0; m_ptr[l] = 0; end
         return;
      end
      for (int i = 0; i < NB; i++) begin
         rdy[i] = (mq[i].size() < FD);
         hv[i]  = (mq[i].size() > 0);
         hd[i]  = hv[i] ? mq[i][0].dst : -1;
         pp[i]  = 1'b0;
      end
      for (int l = 0; l < NL; l++) begin
         if (!m_ov[l] || out_ready[l]) begin
            g = -1;
            for (int k = 0; k < NB; k++) begin
               b = (m_ptr[l] + k) % NB;
               if (g < 0 && hv[b] && hd[b] == l) g = b;
            end
            if (g >= 0) begin
               m_ov[l] = 1'b1; m_val[l] = mq[g][0].data; m_src[l] = g;
               m_ptr[l] = (g + 1) % NB; pp[g] = 1'b1;
            end else m_ov[l] = 1'b0;
         end
      end
      for (int i = 0; i < NB; i++)
         if (hv[i] && hd[i] >= NL) begin pp[i] = 1'b1; m_derr = 1'b1; end
      for (int i = 0; i < NB; i++) if (pp[i]) mq[i].delete(0);
      for (int i = 0; i < NB; i++)
         if (bank_valid[i] && rdy[i]) begin
            w.dst = int'(bank_dst[i]); w.data = bank_val[i];
            mq[i].push_back(w);
         end
   endtask

   task automatic check_outputs();
      logic [NB-1:0] rdy;
      for (int i = 0; i < NB; i++) rdy[i] = (mq[i].size() < FD);
      chk("out_valid", out_valid, m_ov);
      chk("bank_ready", bank_ready, rdy);
      chk("drop_err", drop_err, m_derr);
      for (int l = 0; l < NL; l++)
         if (m_ov[l]) chk($sformatf("lane%0d", l), {out_src[l], out_val[l]}, {BW'(m_src[l]), m_val[l]});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   initial begin
      int ord[$];
      logic [31:0] got[$];
      logic [NL-1:0] exp5;

      rst_n = 1'b0; bank_valid = '0; bank_val = '0; bank_dst = '0; out_ready = '1;
      cyc(); cyc();
      chk("rst_ovalid", out_valid, 0);
      chk("rst_drop", drop_err, 0);
      chk("rst_ready", bank_ready, 4'hF);
      rst_n = 1'b1;
      cyc();

      // Single word: bank 2 -> lane 5.
      bank_valid[2] = 1'b1; bank_dst[2] = 5; bank_val[2] = 32'hDEADBEEF;
      cyc();
      bank_valid = '0;
      chk("t1_early", out_valid, 0);
      cyc();
      exp5 = '0; exp5[5] = 1'b1;
      chk("t1_valid", out_valid, exp5);
      chk("t1_src", out_src[5], 2);
      chk("t1_data", out_val[5], 32'hDEADBEEF);
      cyc();

      // All banks hammer lane 7; grants must rotate 0,1,2,3.
      for (int i = 0; i < 45; i++) begin
         for (int b = 0; b < NB; b++) begin
            bank_valid[b] = (i < 8); bank_dst[b] = 7; bank_val[b] = 32'(b * 256 + i);
         end
         cyc();
         if (out_valid[7]) ord.push_back(int'(out_src[7]));
      end
      bank_valid = '0;
      chk("t2_count", ord.size(), 32);
      for (int k = 0; k < ord.size() && k < 32; k++) chk("t2_order", ord[k], k % 4);

      // Lane 3 stalled while bank 1 fills up, then released.
      out_ready[3] = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bank_valid[1] = 1'b1; bank_dst[1] = 3; bank_val[1] = 32'(100 + i);
         cyc();
      end
      bank_valid = '0;
      chk("t3_full", bank_ready[1], 0);
      out_ready[3] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid[3]) got.push_back(out_val[3]);
         cyc();
      end
      chk("t3_count", got.size(), 17);
      for (int k = 0; k < got.size() && k < 17; k++) chk("t3_order", got[k], 100 + k);

      // Head-of-line blocking: bank 0 stuck behind stalled lane 4.
      out_ready[4] = 1'b0;
      bank_valid[0] = 1'b1; bank_dst[0] = 4; bank_val[0] = 32'hA;   cyc();
      bank_dst[0] = 4; bank_val[0] = 32'hB;                        cyc();
      bank_dst[0] = 9; bank_val[0] = 32'hC0FFEE;                   cyc();
      bank_valid = '0;
      for (int i = 0; i < 4; i++) begin cyc(); chk("t4_hol", out_valid[9], 0); end
      out_ready[4] = 1'b1;
      cyc();
      chk("t4_hol_rel", out_valid[9], 0);
      cyc();
      chk("t4_l9_valid", out_valid[9], 1);
      chk("t4_l9_data", out_val[9], 32'hC0FFEE);
      cyc(); cyc();

      // Out-of-range destination is dropped, next word goes through.
      chk("t5_pre", drop_err, 0);
      bank_valid[3] = 1'b1; bank_dst[3] = 30; bank_val[3] = 32'h3030;
      cyc();
      bank_valid = '0;
      cyc();
      chk("t5_drop", drop_err, 1);
      bank_valid[3] = 1'b1; bank_dst[3] = 2; bank_val[3] = 32'h2222;
      cyc();
      bank_valid = '0;
      cyc();
      chk("t5_l2_valid", out_valid[2], 1);
      chk("t5_l2_src", out_src[2], 3);
      chk("t5_l2_data", out_val[2], 32'h2222);

      // Random traffic with random back-pressure.
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < NB; b++) begin
            bank_valid[b] = ($urandom_range(0, 2) != 0);
            bank_dst[b]   = LW'($urandom_range(0, 27));
            bank_val[b]   = $urandom;
         end
         for (int l = 0; l < NL; l++) out_ready[l] = ($urandom_range(0, 3) != 0);
         cyc();
      end
      bank_valid = '0; out_ready = '1;
      for (int i = 0; i < 80; i++) cyc();

      // Fill, reset mid-operation, nothing stale may emerge.
      out_ready = '0;
      for (int i = 0; i < 10; i++) begin
         for (int b = 0; b < NB; b++) begin
            bank_valid[b] = 1'b1;
            bank_dst[b]   = LW'($urandom_range(0, NL - 1));
            bank_val[b]   = $urandom;
         end
         cyc();
      end
      bank_valid = '0;
      bank_valid[3] = 1'b1; bank_dst[3] = 31;
      cyc();
      bank_valid = '0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("t7_ovalid", out_valid, 0);
      chk("t7_drop", drop_err, 0);
      out_ready = '1;
      for (int i = 0; i < 20; i++) begin cyc(); chk("t7_ghost", out_valid, 0); end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
